fb_store_sink: RTL
==================

FB_STORE_SINK -- requirements
Module: fb_store_sink

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning pixel FIFO entries (power of two, 2..32).
REQ-002 SHALL have parameter FB_BASE, default 10'h041, meaning the value of addr[31:22] that selects the framebuffer window at 0x1040_0000.
REQ-003 SHALL have parameter H_ACTIVE, default 800, meaning the exclusive upper bound for x.
REQ-004 SHALL have parameter V_ACTIVE, default 600, meaning the exclusive upper bound for y.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, the asynchronous active-low reset.
REQ-007 SHALL have port st_en, input, 1, meaning the CPU data-side access is valid this cycle.
REQ-008 SHALL have port st_we, input, 1, meaning the access is a word store.
REQ-009 SHALL have port st_addr, input, 32, meaning the byte address of the store.
REQ-010 SHALL have port st_data, input, 32, meaning the store data; bits [23:0] are RGB.
REQ-011 SHALL have port stall, output, 1, meaning the store cannot be taken and the CPU must hold it.
REQ-012 SHALL have port fb_valid, output, 1, meaning a pixel write is presented.
REQ-013 SHALL have port fb_ready, input, 1, meaning the framebuffer accepts the presented pixel.
REQ-014 SHALL have port fb_x, output, 10, meaning the pixel column.
REQ-015 SHALL have port fb_y, output, 10, meaning the pixel row.
REQ-016 SHALL have port fb_rgb, output, 24, meaning the pixel colour.
REQ-017 SHALL have port drop_cnt, output, 16, meaning the count of out-of-range framebuffer stores.

Function
REQ-018 SHALL define a hit as st_en & st_we & (st_addr[31:22]==FB_BASE); all other accesses are ignored, never stalled, and never counted.
REQ-019 SHALL decode x = st_addr[11:2] and y = st_addr[21:12]; st_addr[1:0] ignored.
REQ-020 SHALL treat a hit with x>=H_ACTIVE or y>=V_ACTIVE as a drop: not queued, drop_cnt +1, saturating at 16'hFFFF, never stalled.
REQ-021 SHALL drive stall = in-range hit & FIFO full, combinationally; a stalled store is not pushed and SHALL be re-presented by the CPU.
REQ-022 SHALL push {x,y,rgb} for an in-range hit when the FIFO is not full.
REQ-023 SHALL present the FIFO head on fb_x/fb_y/fb_rgb with fb_valid=1 whenever the FIFO is non-empty; a pushed entry into an empty FIFO SHALL appear on the next cycle (1-cycle latency); there is no fall-through.
REQ-024 SHALL pop on fb_valid & fb_ready; while fb_valid & !fb_ready, fb_x/fb_y/fb_rgb SHALL hold stable.
REQ-025 SHALL handle push and pop in the same cycle with occupancy unchanged; a full FIFO with a pop that cycle still asserts stall (stall is a function of pre-edge occupancy only).
REQ-026 SHALL wrap read/write pointers modulo DEPTH and keep strict FIFO order.
REQ-027 SHALL drive fb_x/fb_y/fb_rgb to zero when fb_valid=0.

Reset
REQ-028 SHALL on rst=0 asynchronously clear pointers, occupancy and drop_cnt, forcing fb_valid=0, stall=0, and fb_x/fb_y/fb_rgb=0; queued pixels are discarded, including mid-drain.
REQ-029 SHALL resume accepting stores on the first rising edge after rst deasserts.

Structure
REQ-030 SHALL place the FB_BASE, H_ACTIVE and V_ACTIVE defaults and the 44-bit pixel record width in a shared package, fb_pkg.
REQ-031 SHALL instantiate one sub-module, pixel_fifo, a synchronous FIFO parameterised by width and DEPTH that exposes full and empty flags.

Verification
REQ-032 SHALL cover: store to 0x1040_500C with data 0x0000_FF00 and fb_ready=1 -> next cycle fb_valid=1, fb_x=3, fb_y=5, fb_rgb=0x00FF00 for exactly one cycle.
REQ-033 SHALL cover: store to 0x1040_0E10 (x=900) -> no fb_valid, drop_cnt=1; store to 0x0000_1000 -> no fb_valid, drop_cnt remains 1, stall=0.
REQ-034 SHALL cover: fb_ready=0 with 9 back-to-back in-range stores -> 8 accepted, stall=1 on the 9th; raise fb_ready -> 8 pixels emitted in order, after which the 9th is accepted.
REQ-035 SHALL cover: FIFO half full with a simultaneous push and pop for 20 cycles -> occupancy constant, output sequence matches input.
REQ-036 SHALL cover: rst pulled low with 5 entries queued and fb_ready=0 -> fb_valid=0 immediately; no stale pixel after release.
REQ-037 SHALL cover: 65 540 out-of-range stores -> drop_cnt=16'hFFFF.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the CPU-store-to-framebuffer sink: window/raster defaults
// and the queued pixel record layout.
package fb_pkg;

    localparam logic [9:0]  FB_BASE_DEF  = 10'h041;
    localparam int unsigned H_ACTIVE_DEF = 800;
    localparam int unsigned V_ACTIVE_DEF = 600;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned RGB_W   = 24;
    localparam int unsigned PIX_W   = 2 * COORD_W + RGB_W;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [RGB_W-1:0]   rgb;
    } pixel_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with registered full/empty flags; head is always visible on o_dout.
module pixel_fifo #(
    parameter int unsigned WIDTH = 44,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;

    assign w_push = i_push & ~r_full;
    assign w_pop  = i_pop & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage is not reset; the empty flag gates anything stale.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/fb_store_sink.sv
// Snoops CPU word stores into the framebuffer window, queues in-range pixels and
// replays them on a valid/ready pixel port; out-of-range stores are counted and dropped.
module fb_store_sink
    import fb_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter logic [9:0]  FB_BASE  = FB_BASE_DEF,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_en,
    input  logic        st_we,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        stall,
    output logic        fb_valid,
    input  logic        fb_ready,
    output logic [9:0]  fb_x,
    output logic [9:0]  fb_y,
    output logic [23:0] fb_rgb,
    output logic [15:0] drop_cnt
);

    logic           w_hit;
    logic [9:0]     w_x;
    logic [9:0]     w_y;
    logic           w_in_range;
    logic           w_push;
    logic           w_pop;
    logic           w_drop;
    logic           w_full;
    logic           w_empty;
    pixel_t         w_pix_in;
    pixel_t         w_pix_head;
    logic [PIX_W-1:0] w_fifo_dout;
    logic [15:0]    r_drop_cnt;
    logic           w_unused;

    assign w_hit = st_en & st_we & (st_addr[31:22] == FB_BASE);
    assign w_x   = st_addr[11:2];
    assign w_y   = st_addr[21:12];

    assign w_in_range = (32'(w_x) < H_ACTIVE) && (32'(w_y) < V_ACTIVE);

    // Stall depends only on pre-edge occupancy, so a same-cycle pop never unblocks it.
    assign stall  = w_hit & w_in_range & w_full;
    assign w_push = w_hit & w_in_range & ~w_full;
    assign w_drop = w_hit & ~w_in_range;
    assign w_pop  = fb_valid & fb_ready;

    assign w_pix_in = '{x: w_x, y: w_y, rgb: st_data[23:0]};

    pixel_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (DEPTH)
    ) u_pixel_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_din   (w_pix_in),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    // Head fields read as zero whenever nothing is presented.
    assign w_pix_head = pixel_t'(w_fifo_dout);
    assign fb_valid   = ~w_empty;
    assign fb_x       = fb_valid ? w_pix_head.x   : '0;
    assign fb_y       = fb_valid ? w_pix_head.y   : '0;
    assign fb_rgb     = fb_valid ? w_pix_head.rgb : '0;
    assign drop_cnt   = r_drop_cnt;

    assign w_unused = &{1'b0, st_addr[1:0], st_data[31:24]};

endmodule
